// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out bus between a word source and the bit serializer.
// The master modport belongs to the word source; slave belongs to the serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Word-to-bit serializer: first bit appears 1 cycle after acceptance, one bit per cycle after that.
// One-word holding register lets the next word follow with no gap; din_ready drops while it is full.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    bit_serializer_if.slave  bus
);
    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [CNT_W-1:0] cnt_q;

    logic             xfer;
    logic             at_last;
    logic [WIDTH-1:0] shift_adv;

    // Ready depends only on registered state, never on din_valid.
    assign bus.din_ready = ~hold_full_q & ~reset;
    assign xfer          = bus.din_valid & bus.din_ready;
    assign at_last       = (cnt_q == LAST);
    assign shift_adv     = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        shift_q <= bus.din;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (at_last) begin
                        cnt_q <= '0;
                        // Refill on the last-bit edge so consecutive words run without a bubble.
                        if (hold_full_q) begin
                            shift_q     <= hold_q;
                            hold_full_q <= 1'b0;
                        end else if (xfer) begin
                            shift_q <= bus.din;
                        end else begin
                            shift_q <= shift_adv;
                            state_q <= IDLE;
                        end
                    end else begin
                        shift_q <= shift_adv;
                        cnt_q   <= cnt_q + 1'b1;
                        if (xfer) begin
                            hold_q      <= bus.din;
                            hold_full_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ser_valid = (state_q == SHIFT);
    assign bus.ser_out   = (state_q == SHIFT)
                         ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0])
                         : IDLE_BIT;
    assign bus.ser_first = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.ser_last  = (state_q == SHIFT) && at_last;
    assign bus.busy      = (state_q == SHIFT) || hold_full_q;
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8: parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL provide parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.
REQ-003 The block SHALL provide parameter IDLE_BIT, default 0: level driven on ser_out when no bit is valid.
REQ-004 The block SHALL provide port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL provide port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL provide port din, input, WIDTH bits: parallel word to serialize.
REQ-007 The block SHALL provide port din_valid, input, 1 bit: din holds a word offered for transfer.
REQ-008 The block SHALL provide port din_ready, output, 1 bit: block accepts din this cycle.
REQ-009 The block SHALL provide port ser_out, output, 1 bit: serial bit stream to the sequence detector.
REQ-010 The block SHALL provide port ser_valid, output, 1 bit: ser_out carries a data bit this cycle.
REQ-011 The block SHALL provide port ser_first, output, 1 bit: ser_out is the first bit of a word.
REQ-012 The block SHALL provide port ser_last, output, 1 bit: ser_out is the last bit of a word.
REQ-013 The block SHALL provide port busy, output, 1 bit: shifting, or holding a pending word.

Function
REQ-014 Storage SHALL be one shift register (active word), one holding register (one pending word, flag hold_full) and a bit counter of ceil(log2(WIDTH)) bits.
REQ-015 The state machine SHALL have two states: IDLE (no active word) and SHIFT (active word being output).
REQ-016 din_ready SHALL equal (not hold_full) and (not reset), decoded from registered state only; no combinational path from din_valid.
REQ-017 A transfer SHALL occur on a rising edge where din_valid and din_ready are both 1; no other edge captures din.
REQ-018 In IDLE, a transfer SHALL load din into the shift register, clear the counter and enter SHIFT; hold stays empty.
REQ-019 The first bit of a word accepted in IDLE SHALL appear on ser_out in the cycle immediately after the accepting edge (latency 1 cycle).
REQ-020 In SHIFT, each rising edge SHALL advance exactly one bit and increment the counter; ser_out is taken from the MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of the shift register.
REQ-021 In SHIFT, ser_valid SHALL be 1, ser_first SHALL be 1 when counter=0, and ser_last SHALL be 1 when counter=WIDTH-1.
REQ-022 In SHIFT with counter<WIDTH-1, a transfer SHALL load the holding register and set hold_full.
REQ-023 Last-bit edge (counter=WIDTH-1) with hold_full=1: the hold word SHALL load into the shift register, hold_full clears, counter=0, stay SHIFT; no bubble.
REQ-024 Last-bit edge with hold_full=0 and a transfer: din SHALL load directly into the shift register, counter=0, stay SHIFT; no bubble, hold stays empty.
REQ-025 Last-bit edge with hold_full=0 and no transfer: the block SHALL enter IDLE.
REQ-026 In IDLE: ser_out=IDLE_BIT, ser_valid=0, ser_first=0, ser_last=0.
REQ-027 busy SHALL be 1 when state=SHIFT or hold_full=1, else 0.
REQ-028 Each accepted word SHALL be output exactly once, completely, in acceptance order; din changes after acceptance SHALL not affect output.

Reset
REQ-029 While reset=1: state IDLE, hold_full=0, counter=0, shift and hold registers all zero, ser_out=IDLE_BIT, ser_valid=ser_first=ser_last=0, busy=0, din_ready=0.
REQ-030 Reset asserted mid-word SHALL abort immediately (asynchronously), discarding the active and pending words; no partial bits follow after release.
REQ-031 After reset deasserts, din_ready SHALL be 1 and the first transfer SHALL behave per REQ-018/REQ-019.

Verification
REQ-032 Reset: assert reset -> ser_valid=0, ser_out=0, din_ready=0, busy=0; release -> din_ready=1 with no clock edge needed.
REQ-033 Single word: WIDTH=8, MSB_FIRST=1, din=0x36 accepted in IDLE -> next 8 cycles ser_out=0,0,1,1,0,1,1,0; ser_first in cycle 1; ser_last in cycle 8; then ser_valid=0, busy=0. The downstream detector sees 110110.
REQ-034 Back-to-back: din_valid held with 0xB6 then 0xDB -> 16 consecutive ser_valid=1 cycles, bits 10110110 11011011; din_ready=0 while hold_full=1.
REQ-035 Last-edge direct load: hold empty, din=0xFF offered only on the last-bit edge of the prior word -> no ser_valid gap; hold_full stays 0.
REQ-036 LSB order: MSB_FIRST=0, din=0x01 -> ser_out=1,0,0,0,0,0,0,0.
REQ-037 Mid-word reset: pulse reset after 3 bits of 0x36 with a word pending -> ser_valid=0 immediately, busy=0; next din=0xA5 outputs 1,0,1,0,0,1,0,1 from its first bit.
